// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED pattern generator.
// Every channel runs OFF, ON, BLINK or BURST, timed in base ticks from one shared prescaler.
// Optional feature: define LED_PATTERN_DIM_EN to add a per-channel 4-bit brightness level
// (cfg_level) that PWM-gates the pattern with a free-running 4-bit counter.
//
// Config handshake: a write transfers on a rising clock edge where cfg_valid && cfg_ready.
// The master holds cfg_valid and all cfg_* fields stable until that edge. cfg_ready is
// low only in the tick cycle, so a write and a tick update never hit a channel together.
// Writes to cfg_channel >= CHANNELS are accepted and dropped.
module led_pattern_gen #(
  parameter int CHANNELS = 4,
  parameter int TICK_DIV = 100000,
  parameter int PERIOD_W = 10,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_channel,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [3:0]          cfg_count,
`ifdef LED_PATTERN_DIM_EN
  input  logic [3:0]          cfg_level,
`endif
  output logic [CHANNELS-1:0] led_out,
  output logic                tick_out
);

  localparam int PRE_W = $clog2(TICK_DIV);
  // Phase counters hold up to 4*Peff ticks (the BURST gap) without overflow.
  localparam int CNT_W = PERIOD_W + 2;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    B_PULSE_ON  = 2'd0,
    B_PULSE_OFF = 2'd1,
    B_GAP       = 2'd2
  } burst_t;

  logic [PRE_W-1:0]    presc_q;
  logic                tick;
  logic                wr_fire;

  // Per-channel registered state; bst_q is the BURST FSM state of each channel.
  mode_t               mode_q  [CHANNELS];
  logic [PERIOD_W-1:0] peff_q  [CHANNELS];
  logic [3:0]          count_q [CHANNELS];
  logic [CNT_W-1:0]    phase_q [CHANNELS];
  logic [3:0]          idx_q   [CHANNELS];
  burst_t              bst_q   [CHANNELS];

  // Next-state values; the LED bit is registered from these, so it tracks the new state.
  mode_t               mode_d  [CHANNELS];
  logic [PERIOD_W-1:0] peff_d  [CHANNELS];
  logic [3:0]          count_d [CHANNELS];
  logic [CNT_W-1:0]    phase_d [CHANNELS];
  logic [3:0]          idx_d   [CHANNELS];
  burst_t              bst_d   [CHANNELS];

  logic [CNT_W-1:0]    peff_ext  [CHANNELS];
  logic [CNT_W-1:0]    phase_inc [CHANNELS];
  logic [CNT_W-1:0]    half_d    [CHANNELS];
  logic [CHANNELS-1:0] pat_d;
  logic [CHANNELS-1:0] led_d;

`ifdef LED_PATTERN_DIM_EN
  logic [3:0]          level_q [CHANNELS];
  logic [3:0]          level_d [CHANNELS];
  logic [3:0]          pwm_q;
`endif

  assign tick      = (presc_q == PRE_W'(TICK_DIV - 1));
  assign tick_out  = tick;
  assign cfg_ready = ~tick;
  assign wr_fire   = cfg_valid & cfg_ready;

  // Shared prescaler: counts 0..TICK_DIV-1 and wraps.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

`ifdef LED_PATTERN_DIM_EN
  // Free-running PWM counter for brightness gating.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
    end
  end
`endif

  // Per-channel next state: tick advances the pattern, otherwise a write reloads the channel.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      mode_d[i]    = mode_q[i];
      peff_d[i]    = peff_q[i];
      count_d[i]   = count_q[i];
      phase_d[i]   = phase_q[i];
      idx_d[i]     = idx_q[i];
      bst_d[i]     = bst_q[i];
`ifdef LED_PATTERN_DIM_EN
      level_d[i]   = level_q[i];
`endif
      peff_ext[i]  = {2'b00, peff_q[i]};
      phase_inc[i] = phase_q[i] + CNT_W'(1);

      if (tick) begin
        if (mode_q[i] == MODE_BLINK) begin
          phase_d[i] = (phase_inc[i] == peff_ext[i]) ? '0 : phase_inc[i];
        end else if (mode_q[i] == MODE_BURST) begin
          if (count_q[i] == 4'd0) begin
            // No pulses requested: park in GAP with the LED dark.
            bst_d[i]   = B_GAP;
            phase_d[i] = '0;
            idx_d[i]   = '0;
          end else begin
            case (bst_q[i])
              B_PULSE_ON: begin
                if (phase_inc[i] == peff_ext[i]) begin
                  phase_d[i] = '0;
                  bst_d[i]   = B_PULSE_OFF;
                end else begin
                  phase_d[i] = phase_inc[i];
                end
              end
              B_PULSE_OFF: begin
                if (phase_inc[i] == peff_ext[i]) begin
                  phase_d[i] = '0;
                  idx_d[i]   = idx_q[i] + 4'd1;
                  bst_d[i]   = ((idx_q[i] + 4'd1) == count_q[i]) ? B_GAP : B_PULSE_ON;
                end else begin
                  phase_d[i] = phase_inc[i];
                end
              end
              default: begin
                if (phase_inc[i] == {peff_q[i], 2'b00}) begin
                  phase_d[i] = '0;
                  idx_d[i]   = '0;
                  bst_d[i]   = B_PULSE_ON;
                end else begin
                  phase_d[i] = phase_inc[i];
                end
              end
            endcase
          end
        end
      end else if (wr_fire && (int'(cfg_channel) == i)) begin
        mode_d[i]  = mode_t'(cfg_mode);
        peff_d[i]  = (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;
        count_d[i] = cfg_count;
        phase_d[i] = '0;
        idx_d[i]   = '0;
        bst_d[i]   = B_PULSE_ON;
`ifdef LED_PATTERN_DIM_EN
        level_d[i] = cfg_level;
`endif
      end

      // BLINK is lit for the first ceil(Peff/2) phases of each period.
      half_d[i] = ({2'b00, peff_d[i]} + CNT_W'(1)) >> 1;
      case (mode_d[i])
        MODE_OFF:   pat_d[i] = 1'b0;
        MODE_ON:    pat_d[i] = 1'b1;
        MODE_BLINK: pat_d[i] = (phase_d[i] < half_d[i]);
        default:    pat_d[i] = (bst_d[i] == B_PULSE_ON) && (count_d[i] != 4'd0);
      endcase

`ifdef LED_PATTERN_DIM_EN
      led_d[i] = pat_d[i] && ((level_d[i] == 4'hF) || (pwm_q < level_d[i]));
`else
      led_d[i] = pat_d[i];
`endif
    end
  end

  // Channel state and LED drive registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= MODE_OFF;
        peff_q[i]  <= PERIOD_W'(1);
        count_q[i] <= '0;
        phase_q[i] <= '0;
        idx_q[i]   <= '0;
        bst_q[i]   <= B_PULSE_ON;
`ifdef LED_PATTERN_DIM_EN
        level_q[i] <= 4'hF;
`endif
      end
      led_out <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= mode_d[i];
        peff_q[i]  <= peff_d[i];
        count_q[i] <= count_d[i];
        phase_q[i] <= phase_d[i];
        idx_q[i]   <= idx_d[i];
        bst_q[i]   <= bst_d[i];
`ifdef LED_PATTERN_DIM_EN
        level_q[i] <= level_d[i];
`endif
      end
      led_out <= led_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen (TICK_DIV=4). A second instance with CHANNELS=3 shares
// the config bus so that channel 3 is an out-of-range target for it.
`timescale 1ns/1ps
module tb_led_pattern_gen;
  localparam int CH = 4;
  localparam int TD = 4;
  localparam int PW = 10;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [1:0]    cfg_channel = '0;
  logic [1:0]    cfg_mode = '0;
  logic [PW-1:0] cfg_period = '0;
  logic [3:0]    cfg_count = '0;
  logic [3:0]    cfg_level = 4'hF;
  logic          cfg_ready, tick_out, cfg_ready3, tick_out3;
  logic [CH-1:0] led_out;
  logic [2:0]    led_out3;

  always #5 clock = ~clock;

  led_pattern_gen #(.CHANNELS(CH), .TICK_DIV(TD), .PERIOD_W(PW)) dut (
    .clock(clock), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_channel(cfg_channel), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_count(cfg_count),
`ifdef LED_PATTERN_DIM_EN
    .cfg_level(cfg_level),
`endif
    .led_out(led_out), .tick_out(tick_out)
  );

  led_pattern_gen #(.CHANNELS(3), .TICK_DIV(TD), .PERIOD_W(PW)) dut3 (
    .clock(clock), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3),
    .cfg_channel(cfg_channel), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_count(cfg_count),
`ifdef LED_PATTERN_DIM_EN
    .cfg_level(cfg_level),
`endif
    .led_out(led_out3), .tick_out(tick_out3)
  );

  // ---------------- reference model + scoreboard ----------------
  int nerr = 0;
  int nchk = 0;
  int m_presc, m_pwm;
  int m_mode[CH], m_peff[CH], m_count[CH], m_level[CH], m_k[CH];
  logic exp_tick;
  logic [CH-1:0] exp_q[$];

  task automatic model_reset();
    m_presc = 0;
    m_pwm = 0;
    exp_tick = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_mode[c] = 0; m_peff[c] = 1; m_count[c] = 0; m_level[c] = 15; m_k[c] = 0;
    end
  endtask

  // Pattern of a channel after k ticks since its last write, from the mode rules.
  function automatic logic pat(int c);
    int p, n, k, r;
    p = m_peff[c]; n = m_count[c]; k = m_k[c];
    case (m_mode[c])
      0: return 1'b0;
      1: return 1'b1;
      2: return (k % p) < ((p + 1) / 2);
      default: begin
        if (n == 0) return 1'b0;
        r = k % (2 * p * n + 4 * p);
        return (r < 2 * p * n) && ((r % (2 * p)) < p);
      end
    endcase
  endfunction

  // Advance one clock: predict the edge, push the expected LEDs, then wait for it.
  task automatic step();
    logic tk, xfer;
    logic [CH-1:0] e;
    xfer = 1'b0;
    e = '0;
    if (!resetn) begin
      model_reset();
    end else begin
      tk = (m_presc == TD - 1);
      if (tk) begin
        for (int c = 0; c < CH; c++) m_k[c]++;
      end else if (cfg_valid) begin
        xfer = 1'b1;
        if (int'(cfg_channel) < CH) begin
          m_mode[cfg_channel]  = int'(cfg_mode);
          m_peff[cfg_channel]  = (cfg_period == 0) ? 1 : int'(cfg_period);
          m_count[cfg_channel] = int'(cfg_count);
          m_k[cfg_channel]     = 0;
`ifdef LED_PATTERN_DIM_EN
          m_level[cfg_channel] = int'(cfg_level);
`endif
        end
      end
      m_presc = tk ? 0 : m_presc + 1;
      for (int c = 0; c < CH; c++)
        e[c] = pat(c) && (m_level[c] == 15 || m_pwm < m_level[c]);
      m_pwm = (m_pwm + 1) % 16;
      exp_tick = (m_presc == TD - 1);
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (xfer) cfg_valid = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_write(input int ch, input int mode, input int period, input int count,
                             input int level);
    cfg_channel = ch[1:0];
    cfg_mode    = mode[1:0];
    cfg_period  = period[PW-1:0];
    cfg_count   = count[3:0];
    cfg_level   = level[3:0];
    cfg_valid   = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [CH-1:0] e;
    int n;
    resetn = 1'b0;
    repeat (3) begin
      step(); e = exp_q.pop_front();
      nchk++;
      if ({led_out, cfg_ready, tick_out, led_out3} !== {4'b0000, 1'b1, 1'b0, 3'b000}) begin
        nerr++; $display("FAIL reset_hold: got %b expected %b", {led_out, cfg_ready, tick_out, led_out3}, 9'b0000_1_0_000);
      end
    end
    resetn = 1'b1;
    n = 0;
    while (tick_out !== 1'b1 && n < 10) begin
      step(); e = exp_q.pop_front(); n++;
      nchk++;
      if ({led_out, tick_out, cfg_ready, led_out3, tick_out3, cfg_ready3} !== {e, exp_tick, ~exp_tick, e[2:0], exp_tick, ~exp_tick}) begin
        nerr++; $display("FAIL reset_release: got %b expected %b", {led_out, tick_out, cfg_ready, led_out3, tick_out3, cfg_ready3}, {e, exp_tick, ~exp_tick, e[2:0], exp_tick, ~exp_tick});
      end
    end
    nchk++;
    if (n !== 3) begin nerr++; $display("FAIL first_tick: edges to first tick %0d expected 3", n); end
  endtask

  task automatic test_blink();
    logic [CH-1:0] e;
    int ones;
    start_write(0, 2, 4, 0, 15);
    ones = 0;
    for (int i = 0; i < 84; i++) begin
      step(); e = exp_q.pop_front();
      if (i >= 20) ones += int'(led_out[0]);
      nchk++;
      if ({led_out, tick_out, cfg_ready, led_out3, tick_out3, cfg_ready3} !== {e, exp_tick, ~exp_tick, e[2:0], exp_tick, ~exp_tick}) begin
        nerr++; $display("FAIL blink: got %b expected %b", {led_out, tick_out, cfg_ready, led_out3, tick_out3, cfg_ready3}, {e, exp_tick, ~exp_tick, e[2:0], exp_tick, ~exp_tick});
      end
    end
    nchk++;
    if (ones !== 32) begin nerr++; $display("FAIL blink_duty: high clocks %0d of 64 expected 32", ones); end
    nchk++;
    if (led_out[3:1] !== 3'b000) begin nerr++; $display("FAIL blink_others: got %b expected 000", led_out[3:1]); end
  endtask

  task automatic test_burst();
    logic [CH-1:0] e;
    int ones;
    start_write(1, 3, 2, 3, 15);
    ones = 0;
    for (int i = 0; i < 180; i++) begin
      step(); e = exp_q.pop_front();
      if (i >= 100) ones += int'(led_out[1]);
      nchk++;
      if ({led_out, tick_out, cfg_ready, led_out3, tick_out3, cfg_ready3} !== {e, exp_tick, ~exp_tick, e[2:0], exp_tick, ~exp_tick}) begin
        nerr++; $display("FAIL burst: got %b expected %b", {led_out, tick_out, cfg_ready, led_out3, tick_out3, cfg_ready3}, {e, exp_tick, ~exp_tick, e[2:0], exp_tick, ~exp_tick});
      end
    end
    nchk++;
    if (ones !== 24) begin nerr++; $display("FAIL burst_duty: high clocks %0d of 80 expected 24", ones); end
  endtask

  task automatic test_collision();
    logic [CH-1:0] e;
    int n;
    n = 0;
    while (tick_out !== 1'b1 && n < 10) begin
      step(); e = exp_q.pop_front(); n++;
      nchk++;
      if ({led_out, tick_out, cfg_ready} !== {e, exp_tick, ~exp_tick}) begin
        nerr++; $display("FAIL coll_wait: got %b expected %b", {led_out, tick_out, cfg_ready}, {e, exp_tick, ~exp_tick});
      end
    end
    nchk++;
    if (tick_out !== 1'b1) begin nerr++; $display("FAIL coll_tick: tick_out %b expected 1 within 10 clocks", tick_out); end
    start_write(2, 2, 4, 0, 15);
    nchk++;
    if (cfg_ready !== 1'b0) begin nerr++; $display("FAIL coll_ready: cfg_ready %b expected 0", cfg_ready); end
    step(); e = exp_q.pop_front();
    nchk++;
    if ({led_out[2], cfg_ready, led_out} !== {1'b0, 1'b1, e}) begin
      nerr++; $display("FAIL coll_hold: got %b expected %b", {led_out[2], cfg_ready, led_out}, {1'b0, 1'b1, e});
    end
    step(); e = exp_q.pop_front();
    nchk++;
    if ({led_out[2], cfg_valid, led_out} !== {1'b1, 1'b0, e}) begin
      nerr++; $display("FAIL coll_xfer: got %b expected %b", {led_out[2], cfg_valid, led_out}, {1'b1, 1'b0, e});
    end
    repeat (40) begin
      step(); e = exp_q.pop_front();
      nchk++;
      if ({led_out, tick_out, cfg_ready, led_out3} !== {e, exp_tick, ~exp_tick, e[2:0]}) begin
        nerr++; $display("FAIL coll_after: got %b expected %b", {led_out, tick_out, cfg_ready, led_out3}, {e, exp_tick, ~exp_tick, e[2:0]});
      end
    end
  endtask

  task automatic test_degenerate();
    logic [CH-1:0] e;
    int bad;
    start_write(0, 2, 0, 0, 15);   // BLINK with period 0 -> steady on
    repeat (4) begin step(); e = exp_q.pop_front(); end
    start_write(1, 3, 5, 0, 15);   // BURST with count 0 -> steady off
    repeat (4) begin step(); e = exp_q.pop_front(); end
    start_write(2, 0, 3, 3, 15);   // OFF
    repeat (4) begin step(); e = exp_q.pop_front(); end
    start_write(3, 1, 0, 0, 15);   // ON; out of range for the 3-channel instance
    bad = 0;
    repeat (40) begin
      step(); e = exp_q.pop_front();
      if (led_out !== 4'b1001 || led_out3 !== 3'b001) bad++;
      nchk++;
      if ({led_out, tick_out, cfg_ready, led_out3, tick_out3, cfg_ready3} !== {e, exp_tick, ~exp_tick, e[2:0], exp_tick, ~exp_tick}) begin
        nerr++; $display("FAIL degenerate: got %b expected %b", {led_out, tick_out, cfg_ready, led_out3, tick_out3, cfg_ready3}, {e, exp_tick, ~exp_tick, e[2:0], exp_tick, ~exp_tick});
      end
    end
    nchk++;
    if (bad !== 0) begin nerr++; $display("FAIL degenerate_steady: %0d clocks off steady value, expected 0", bad); end
  endtask

`ifdef LED_PATTERN_DIM_EN
  task automatic test_dim();
    logic [CH-1:0] e;
    int lv[3];
    int want[3];
    int ones;
    lv[0] = 4; lv[1] = 15; lv[2] = 0;
    want[0] = 8; want[1] = 32; want[2] = 0;
    for (int t = 0; t < 3; t++) begin
      start_write(2, 1, 1, 0, lv[t]);
      ones = 0;
      for (int i = 0; i < 40; i++) begin
        step(); e = exp_q.pop_front();
        if (i >= 8) ones += int'(led_out[2]);
        nchk++;
        if ({led_out, led_out3} !== {e, e[2:0]}) begin
          nerr++; $display("FAIL dim: got %b expected %b", {led_out, led_out3}, {e, e[2:0]});
        end
      end
      nchk++;
      if (ones !== want[t]) begin nerr++; $display("FAIL dim_duty: level %0d high %0d of 32 expected %0d", lv[t], ones, want[t]); end
    end
  endtask
`endif

  task automatic test_random();
    logic [CH-1:0] e;
    for (int it = 0; it < 40; it++) begin
      start_write($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(5, 0),
                  $urandom_range(4, 0), $urandom_range(15, 0));
      repeat ($urandom_range(60, 3)) begin
        step(); e = exp_q.pop_front();
        nchk++;
        if ({led_out, tick_out, cfg_ready, led_out3, tick_out3, cfg_ready3} !== {e, exp_tick, ~exp_tick, e[2:0], exp_tick, ~exp_tick}) begin
          nerr++; $display("FAIL random: got %b expected %b", {led_out, tick_out, cfg_ready, led_out3, tick_out3, cfg_ready3}, {e, exp_tick, ~exp_tick, e[2:0], exp_tick, ~exp_tick});
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [CH-1:0] e;
    int n;
    start_write(0, 2, 4, 0, 15);
    repeat (6) begin step(); e = exp_q.pop_front(); end
    #2 resetn = 1'b0;              // between edges
    #1;
    nchk++;
    if ({led_out, led_out3} !== 7'b0) begin nerr++; $display("FAIL async_reset: got %b expected 0000000", {led_out, led_out3}); end
    model_reset();
    repeat (3) begin
      step(); e = exp_q.pop_front();
      nchk++;
      if ({led_out, cfg_ready, tick_out} !== {4'b0000, 1'b1, 1'b0}) begin
        nerr++; $display("FAIL async_hold: got %b expected 000010", {led_out, cfg_ready, tick_out});
      end
    end
    resetn = 1'b1;
    n = 0;
    while (tick_out !== 1'b1 && n < 10) begin
      step(); e = exp_q.pop_front(); n++;
      nchk++;
      if ({led_out, tick_out, cfg_ready} !== {e, exp_tick, ~exp_tick}) begin
        nerr++; $display("FAIL async_release: got %b expected %b", {led_out, tick_out, cfg_ready}, {e, exp_tick, ~exp_tick});
      end
    end
    nchk++;
    if (n !== 3) begin nerr++; $display("FAIL async_first_tick: edges %0d expected 3", n); end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    model_reset();
    #1;
    test_reset();
    test_blink();
    test_burst();
    test_collision();
    test_degenerate();
`ifdef LED_PATTERN_DIM_EN
    test_dim();
`endif
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
